dac_tdm_interleaver: RTL
========================

DAC_TDM_INTERLEAVER -- requirements
Module: dac_tdm_interleaver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14: sample width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2: channel count, power of two, 2..8.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: cycles dac_rst_o is held after reset release.
REQ-004 SHALL have parameter SLEW_STEP, default 64: maximum per-frame change of a channel (slew build only).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port din, input, NUM_CH*DATA_WIDTH: two's-complement samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port din_valid, input, 1: din holds a new sample set.
REQ-009 SHALL have port din_ready, output, 1: block accepts din this cycle.
REQ-010 SHALL have port mute_req, input, 1: level request to force midscale output.
REQ-011 SHALL have port dout, output, DATA_WIDTH: offset-binary DAC code.
REQ-012 SHALL have port dout_sel, output, clog2(NUM_CH): channel index of dout.
REQ-013 SHALL have port dout_wrt, output, 1: dout/dout_sel valid this cycle.
REQ-014 SHALL have port dac_rst_o, output, 1: DAC reset, active-high.
REQ-015 SHALL have port muted, output, 1: high while midscale is being output.

Function
REQ-016 SHALL hold a shadow register set, loaded on every cycle where din_valid and din_ready are both high.
REQ-017 SHALL run a slot counter 0..NUM_CH-1 that wraps; one frame = NUM_CH cycles; counter is free-running outside HOLD.
REQ-018 SHALL copy shadow to the active set on the edge that ends slot NUM_CH-1, only if a new set was accepted since the last copy; a set accepted on that same edge SHALL bypass into the active set.
REQ-019 SHALL register outputs: in slot k, dout = active[k] with MSB inverted, dout_sel = k, dout_wrt = 1; latency from an accepted set to its first output = 1 to NUM_CH+1 cycles.
REQ-020 SHALL implement FSM HOLD -> MUTE -> RUN: HOLD lasts HOLD_CYCLES after rst_n rises, then MUTE.
REQ-021 SHALL leave MUTE for RUN at the next frame boundary where mute_req is low.
REQ-022 SHALL leave RUN for MUTE at the next frame boundary after mute_req rises; frames are never truncated.
REQ-023 SHALL output dout = 1<<(DATA_WIDTH-1) (midscale) in every slot in HOLD and MUTE, with muted = 1.
REQ-024 SHALL drive din_ready low only in HOLD; accepting data in MUTE updates shadow/active but not dout.
REQ-025 SHALL drive dac_rst_o = 1 in HOLD only, and dout_wrt = 0 in HOLD.

Reset
REQ-026 SHALL, while rst_n is low, force: state HOLD, slot 0, shadow/active 0, pending 0, dout midscale, dout_sel 0, dout_wrt 0, dac_rst_o 1, din_ready 0, muted 1.
REQ-027 SHALL, on rst_n asserted mid-frame or mid-transfer, discard all pending data, with no partial frame resumed.

Configuration
REQ-028 SHALL, with macro DAC_SLEW_LIMIT_EN defined, move each active channel toward its shadow value by at most SLEW_STEP per frame boundary, landing exactly on target with no overshoot and saturating arithmetic with no wrap.
REQ-029 SHALL, without DAC_SLEW_LIMIT_EN, copy shadow to active in one step per REQ-018, with SLEW_STEP unused.

Structure
REQ-030 SHALL place the FSM state enum, the midscale constant function and the slot-width function in package dac_pkg.
REQ-031 SHALL put per-channel slew logic in sub-module dac_slew_ch, instantiated NUM_CH times under DAC_SLEW_LIMIT_EN.

Verification
REQ-032 SHALL cover: rst_n low then released -> dac_rst_o high exactly 16 cycles, then dout_wrt toggling slots 0,1 with dout=0x2000.
REQ-033 SHALL cover: RUN, accept ch0=0x0000, ch1=0x1FFF -> next frame dout 0x2000 sel0, 0x3FFF sel1.
REQ-034 SHALL cover: accept on the edge ending slot 1 -> new values at the immediately following slot 0.
REQ-035 SHALL cover: mute_req pulsed in slot 0 -> current frame completes, following frames 0x2000, muted=1, RUN resumes at first boundary after deassert.
REQ-036 SHALL cover, slew build: ch0 step 0 -> 200 -> successive frames 64, 128, 192, 200, then stable.
REQ-037 SHALL cover: rst_n pulsed low mid-frame -> outputs immediately at reset values, pending set lost.

Source files
------------

// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state type and sizing helpers for the DAC TDM interleaver
package dac_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_MUTE = 2'd1,
        ST_RUN  = 2'd2
    } dac_state_e;

    // Offset-binary midscale code; also the MSB mask that converts two's complement.
    function automatic logic [31:0] midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

    function automatic int slot_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/dac_slew_ch.sv
// rtl/dac_slew_ch.sv - one channel's bounded step toward its target value
module dac_slew_ch #(
    parameter int DATA_WIDTH = 14,
    parameter int SLEW_STEP  = 64
) (
    input  logic [DATA_WIDTH-1:0] i_cur,
    input  logic [DATA_WIDTH-1:0] i_target,
    output logic [DATA_WIDTH-1:0] o_next
);

    localparam logic signed [DATA_WIDTH:0] STEP_S = (DATA_WIDTH + 1)'(SLEW_STEP);
    localparam logic [DATA_WIDTH-1:0]      STEP_U = DATA_WIDTH'(SLEW_STEP);

    logic signed [DATA_WIDTH:0] w_diff;

    // One extra bit keeps the difference exact; the stepped result always lies
    // between cur and target, so it can never wrap.
    assign w_diff = $signed({i_target[DATA_WIDTH-1], i_target})
                  - $signed({i_cur[DATA_WIDTH-1], i_cur});

    always_comb begin
        o_next = i_target;
        if (w_diff > STEP_S) begin
            o_next = i_cur + STEP_U;
        end else if (w_diff < -STEP_S) begin
            o_next = i_cur - STEP_U;
        end
    end

endmodule

// File: rtl/dac_tdm_interleaver.sv
// rtl/dac_tdm_interleaver.sv - TDM channel interleaver for a single-port DAC; DAC_SLEW_LIMIT_EN enables slew limiting
module dac_tdm_interleaver
    import dac_pkg::*;
#(
    parameter int DATA_WIDTH  = 14,
    parameter int NUM_CH      = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int SLEW_STEP   = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   din,
    input  logic                           din_valid,
    output logic                           din_ready,
    input  logic                           mute_req,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic [slot_width(NUM_CH)-1:0]  dout_sel,
    output logic                           dout_wrt,
    output logic                           dac_rst_o,
    output logic                           muted
);

    localparam int                    SW        = slot_width(NUM_CH);
    localparam int                    HW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] MID       = DATA_WIDTH'(midscale(DATA_WIDTH));
    localparam logic [SW-1:0]         LAST_SLOT = SW'(NUM_CH - 1);
    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_CYCLES - 1);

    dac_state_e r_state;
    dac_state_e w_state_next;

    logic [HW-1:0]         r_hold_cnt;
    logic [SW-1:0]         r_slot;
    logic                  r_mute_pend;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] r_shadow [NUM_CH];
    logic [DATA_WIDTH-1:0] r_active [NUM_CH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic [SW-1:0]         r_dout_sel;
    logic                  r_dout_wrt;
    logic                  r_muted;

    logic w_accept;
    logic w_boundary;

    assign din_ready  = (r_state != ST_HOLD);
    assign dac_rst_o  = (r_state == ST_HOLD);
    assign w_accept   = din_valid && din_ready;
    assign w_boundary = (r_state != ST_HOLD) && (r_slot == LAST_SLOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Mode changes only at frame boundaries so a started frame always completes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HOLD: if (r_hold_cnt == HOLD_LAST) w_state_next = ST_MUTE;
            ST_MUTE: if (w_boundary && !mute_req) w_state_next = ST_RUN;
            ST_RUN:  if (w_boundary && (mute_req || r_mute_pend)) w_state_next = ST_MUTE;
            default: w_state_next = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt  <= '0;
            r_slot      <= '0;
            r_mute_pend <= 1'b0;
        end else begin
            if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
                r_slot     <= '0;
            end else begin
                r_hold_cnt <= '0;
                r_slot     <= r_slot + SW'(1);
            end
            // Remembers a mute pulse that drops before the frame ends.
            if (r_state == ST_RUN && !w_boundary) begin
                r_mute_pend <= r_mute_pend | mute_req;
            end else begin
                r_mute_pend <= 1'b0;
            end
        end
    end

`ifdef DAC_SLEW_LIMIT_EN
    logic [DATA_WIDTH-1:0] w_target [NUM_CH];
    logic [DATA_WIDTH-1:0] w_slewed [NUM_CH];
    logic                  w_settled;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slew
        assign w_target[g] = w_accept ? din[g*DATA_WIDTH +: DATA_WIDTH] : r_shadow[g];

        dac_slew_ch #(
            .DATA_WIDTH (DATA_WIDTH),
            .SLEW_STEP  (SLEW_STEP)
        ) u_slew (
            .i_cur    (r_active[g]),
            .i_target (w_target[g]),
            .o_next   (w_slewed[g])
        );
    end

    always_comb begin
        w_settled = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_slewed[k] != w_target[k]) w_settled = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_shadow[k] <= din[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`ifdef DAC_SLEW_LIMIT_EN
            // Pending stays set until every channel has landed on its target.
            if (w_boundary && (r_pending || w_accept)) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    r_active[k] <= w_slewed[k];
                end
                r_pending <= !w_settled;
            end else if (w_accept) begin
                r_pending <= 1'b1;
            end
`else
            if (w_boundary) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (w_accept) begin
                        r_active[k] <= din[k*DATA_WIDTH +: DATA_WIDTH];
                    end else if (r_pending) begin
                        r_active[k] <= r_shadow[k];
                    end
                end
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending <= 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= MID;
            r_dout_sel <= '0;
            r_dout_wrt <= 1'b0;
            r_muted    <= 1'b1;
        end else begin
            r_dout_sel <= r_slot;
            r_dout_wrt <= (r_state != ST_HOLD);
            r_muted    <= (r_state != ST_RUN);
            r_dout     <= (r_state == ST_RUN) ? (r_active[r_slot] ^ MID) : MID;
        end
    end

    assign dout     = r_dout;
    assign dout_sel = r_dout_sel;
    assign dout_wrt = r_dout_wrt;
    assign muted    = r_muted;

endmodule
